change_dispenser_ctrl: RTL and testbench

CHANGE_DISPENSER_CTRL -- requirements
Module: change_dispenser_ctrl

---
 rtl/change_dispenser_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_change_dispenser_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser_ctrl.sv
// Change dispenser controller.
// Accepts a change request, then repeatedly picks the largest coin that still fits the
// remaining amount and is both stocked and not faulted, commands the hopper to eject it and
// waits for an acknowledge. A coin that is never acknowledged within ACK_TIMEOUT cycles marks
// its denomination faulty for the rest of the transaction. Whatever cannot be paid is reported
// as shortfall alongside a one-cycle done pulse.
//
// Denomination bit map (hopper_empty, eject_sel, fault):
//   bit4 = 200c, bit3 = 100c, bit2 = 50c, bit1 = 20c, bit0 = 10c

module change_dispenser_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    // Request side
    input  logic       req_valid,
    input  logic [7:0] req_amount,
    output logic       req_ready,
    // Hopper side
    input  logic [4:0] hopper_empty,
    output logic       eject_valid,
    output logic [4:0] eject_sel,
    input  logic       eject_ack,
    // Status
    output logic       done,
    output logic [7:0] shortfall,
    output logic [4:0] coin_count,
    output logic [4:0] fault
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSelect = 2'd1;
    localparam logic [1:0] StEject  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [7:0] Val200 = 8'd200;
    localparam logic [7:0] Val100 = 8'd100;
    localparam logic [7:0] Val50  = 8'd50;
    localparam logic [7:0] Val20  = 8'd20;
    localparam logic [7:0] Val10  = 8'd10;

    // Timer value seen in the last EJECT cycle before a timeout; the timer counts completed
    // unacknowledged cycles, so the command is held for exactly ACK_TIMEOUT cycles.
    localparam logic [7:0] TimerLast = 8'(ACK_TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------

    logic [1:0] state_q, state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [4:0] sel_q, sel_d;
    logic [7:0] timer_q, timer_d;
    logic [4:0] coin_count_q, coin_count_d;
    logic [4:0] fault_q, fault_d;

    // ------------------------------------------------------------------------
    // Denomination helpers
    // ------------------------------------------------------------------------

    logic [4:0] fits;       // denominations not larger than the remaining amount
    logic [4:0] candidates; // denominations that may be ejected right now
    logic [4:0] pick;       // one-hot: largest candidate, or zero if none
    logic [7:0] sel_value;  // cents represented by the registered selection

    // Compare the remaining amount against each coin value
    always_comb begin
        fits[4] = (Val200 <= remaining_q);
        fits[3] = (Val100 <= remaining_q);
        fits[2] = (Val50  <= remaining_q);
        fits[1] = (Val20  <= remaining_q);
        fits[0] = (Val10  <= remaining_q);
    end

    assign candidates = fits & ~hopper_empty & ~fault_q;

    // Priority pick of the largest available denomination
    always_comb begin
        pick = 5'b00000;
        if (candidates[4]) begin
            pick = 5'b10000;
        end else if (candidates[3]) begin
            pick = 5'b01000;
        end else if (candidates[2]) begin
            pick = 5'b00100;
        end else if (candidates[1]) begin
            pick = 5'b00010;
        end else if (candidates[0]) begin
            pick = 5'b00001;
        end
    end

    // Value of the coin currently being ejected; sel_q is one-hot whenever it is used
    always_comb begin
        sel_value = 8'd0;
        unique case (sel_q)
            5'b10000: sel_value = Val200;
            5'b01000: sel_value = Val100;
            5'b00100: sel_value = Val50;
            5'b00010: sel_value = Val20;
            5'b00001: sel_value = Val10;
            default:  sel_value = 8'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------

    // Transaction sequencing: accept, select, eject/wait, report
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        sel_d        = sel_q;
        timer_d      = timer_q;
        coin_count_d = coin_count_q;
        fault_d      = fault_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    remaining_d  = req_amount;
                    coin_count_d = 5'd0;
                    fault_d      = 5'd0;
                    state_d      = StSelect;
                end
            end

            StSelect: begin
                // hopper_empty only matters here; later changes cannot disturb an eject
                if (pick != 5'b00000) begin
                    sel_d   = pick;
                    timer_d = 8'd0;
                    state_d = StEject;
                end else begin
                    state_d = StDone;
                end
            end

            StEject: begin
                // Acknowledge wins over a timeout landing in the same cycle
                if (eject_ack) begin
                    remaining_d  = remaining_q - sel_value;
                    coin_count_d = coin_count_q + 5'd1;
                    state_d      = StSelect;
                end else if (timer_q == TimerLast) begin
                    fault_d = fault_q | sel_q;
                    state_d = StSelect;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            remaining_q  <= 8'd0;
            sel_q        <= 5'd0;
            timer_q      <= 8'd0;
            coin_count_q <= 5'd0;
            fault_q      <= 5'd0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            sel_q        <= sel_d;
            timer_q      <= timer_d;
            coin_count_q <= coin_count_d;
            fault_q      <= fault_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    // Outputs decoded from state so reset takes effect without a clock edge
    always_comb begin
        req_ready   = (state_q == StIdle);
        eject_valid = (state_q == StEject);
        eject_sel   = (state_q == StEject) ? sel_q : 5'd0;
        done        = (state_q == StDone);
        shortfall   = (state_q == StDone) ? remaining_q : 8'd0;
        coin_count  = coin_count_q;
        fault       = fault_q;
    end

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Directed bench for change_dispenser_ctrl. Inputs are driven and outputs sampled on the
// falling clock edge; the DUT acts on the rising edge.

module tb_change_dispenser_ctrl;

    localparam int unsigned TO = 16;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [7:0] req_amount;
    logic       req_ready;
    logic [4:0] hopper_empty;
    logic       eject_valid;
    logic [4:0] eject_sel;
    logic       eject_ack;
    logic       done;
    logic [7:0] shortfall;
    logic [4:0] coin_count;
    logic [4:0] fault;

    int n_checks = 0;
    int n_errors = 0;

    change_dispenser_ctrl #(
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_amount  (req_amount),
        .req_ready   (req_ready),
        .hopper_empty(hopper_empty),
        .eject_valid (eject_valid),
        .eject_sel   (eject_sel),
        .eject_ack   (eject_ack),
        .done        (done),
        .shortfall   (shortfall),
        .coin_count  (coin_count),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One transaction from an IDLE falling edge back to the IDLE falling edge after done.
    // exp_seq packs the expected eject_sel values, first coin in bits 4:0.
    task automatic run_txn(input string name, input logic [7:0] amount, input logic [4:0] empty,
                           input logic [4:0] noack, input int ack_delay, input bit flip,
                           input bit hold_valid, input logic [19:0] exp_seq, input int exp_n,
                           input logic [7:0] exp_sf, input logic [4:0] exp_cc,
                           input logic [4:0] exp_fault, input int exp_done_c);
        logic [19:0] got_seq;
        logic [4:0]  cur_sel;
        int          n_ej;
        int          dur;
        int          first_c;
        int          c;
        bit          in_ej;
        bit          got_done;
        got_seq  = 20'd0;
        cur_sel  = 5'd0;
        n_ej     = 0;
        dur      = 0;
        first_c  = -1;
        in_ej    = 1'b0;
        got_done = 1'b0;

        check({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_amount   = amount;
        hopper_empty = empty;
        @(posedge clk);
        @(negedge clk);
        if (hold_valid) req_amount = 8'd10;
        else req_valid = 1'b0;

        for (c = 1; c < 300; c++) begin
            if (hold_valid) check({name, "_busy_ready"}, 32'(req_ready), 32'd0);
            if (done) begin
                got_done = 1'b1;
                check({name, "_done_ev"}, 32'(eject_valid), 32'd0);
                check({name, "_shortfall"}, 32'(shortfall), 32'(exp_sf));
                check({name, "_coin_count"}, 32'(coin_count), 32'(exp_cc));
                check({name, "_fault"}, 32'(fault), 32'(exp_fault));
                if (exp_done_c >= 0) check({name, "_done_lat"}, 32'(c), 32'(exp_done_c));
                req_valid = 1'b0;
                eject_ack = 1'b0;
                break;
            end
            if (eject_valid) begin
                if (!in_ej) begin
                    in_ej   = 1'b1;
                    n_ej++;
                    if (n_ej <= 4) got_seq[(n_ej - 1) * 5 +: 5] = eject_sel;
                    if (n_ej == 1) first_c = c;
                    cur_sel = eject_sel;
                    dur     = 1;
                end else begin
                    dur++;
                    check({name, "_sel_hold"}, 32'(eject_sel), 32'(cur_sel));
                end
                // Hopper model: acknowledge after ack_delay cycles unless this coin is jammed
                eject_ack = ((noack & eject_sel) == 5'd0) && ((dur - 1) == ack_delay);
            end else begin
                if (in_ej) begin
                    in_ej = 1'b0;
                    check({name, "_ev_dur"}, 32'(dur),
                          ((noack & cur_sel) != 5'd0) ? 32'(TO) : 32'(ack_delay + 1));
                end
                eject_ack = 1'b0;
            end
            if (flip) hopper_empty = eject_valid ? 5'b11111 : empty;
            @(posedge clk);
            @(negedge clk);
        end

        check({name, "_done_seen"}, 32'(got_done), 32'd1);
        check({name, "_n_ejects"}, 32'(n_ej), 32'(exp_n));
        check({name, "_eject_seq"}, 32'(got_seq), 32'(exp_seq));
        if (exp_n > 0) check({name, "_first_lat"}, 32'(first_c), 32'd2);

        hopper_empty = empty;
        @(posedge clk);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_idle_ready"}, 32'(req_ready), 32'd1);
        check({name, "_cc_hold"}, 32'(coin_count), 32'(exp_cc));
        check({name, "_fault_hold"}, 32'(fault), 32'(exp_fault));
    endtask

    initial begin
        bit saw_done;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_amount   = 8'd0;
        hopper_empty = 5'd0;
        eject_ack    = 1'b0;

        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_ev", 32'(eject_valid), 32'd0);
        check("rst_sel", 32'(eject_sel), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sf", 32'(shortfall), 32'd0);
        check("rst_cc", 32'(coin_count), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 170: 100, 50, 20; hopper_empty toggled during each eject must not matter
        run_txn("t170", 8'd170, 5'b00000, 5'b00000, 1, 1'b1, 1'b0,
                {5'b0, 5'b00010, 5'b00100, 5'b01000}, 3, 8'd0, 5'd3, 5'd0, -1);
        // 255: 200, 50, residue 5
        run_txn("t255", 8'd255, 5'b00000, 5'b00000, 1, 1'b0, 1'b0,
                {10'b0, 5'b00100, 5'b10000}, 2, 8'd5, 5'd2, 5'd0, -1);
        // 60 without 50c: 20, 20, 20
        run_txn("t60", 8'd60, 5'b00100, 5'b00000, 1, 1'b0, 1'b0,
                {5'b0, 5'b00010, 5'b00010, 5'b00010}, 3, 8'd0, 5'd3, 5'd0, -1);
        // 100 with a jammed 100c hopper: timeout, then 50, 50
        run_txn("t100to", 8'd100, 5'b00000, 5'b01000, 1, 1'b0, 1'b0,
                {5'b0, 5'b00100, 5'b00100, 5'b01000}, 3, 8'd0, 5'd2, 5'b01000, -1);
        // Zero amount: straight to done two cycles after accept; fault cleared on accept
        run_txn("t0", 8'd0, 5'b00000, 5'b00000, 1, 1'b0, 1'b0,
                20'd0, 0, 8'd0, 5'd0, 5'd0, 2);
        // Request held high during the transaction is not taken until IDLE
        run_txn("t170hold", 8'd170, 5'b00000, 5'b00000, 0, 1'b0, 1'b1,
                {5'b0, 5'b00010, 5'b00100, 5'b01000}, 3, 8'd0, 5'd3, 5'd0, -1);
        // Ack on the very last timeout cycle wins
        run_txn("t20late", 8'd20, 5'b00000, 5'b00000, TO - 1, 1'b0, 1'b0,
                {15'b0, 5'b00010}, 1, 8'd0, 5'd1, 5'd0, -1);
        // Every hopper empty: full shortfall
        run_txn("t30empty", 8'd30, 5'b11111, 5'b00000, 1, 1'b0, 1'b0,
                20'd0, 0, 8'd30, 5'd0, 5'd0, 2);
        // Only 10c left: four coins
        run_txn("t40", 8'd40, 5'b00010, 5'b00000, 0, 1'b0, 1'b0,
                {5'b00001, 5'b00001, 5'b00001, 5'b00001}, 4, 8'd0, 5'd4, 5'd0, -1);
        // Below the smallest coin
        run_txn("t7", 8'd7, 5'b00000, 5'b00000, 1, 1'b0, 1'b0,
                20'd0, 0, 8'd7, 5'd0, 5'd0, 2);

        // Reset while an eject is pending
        req_valid  = 1'b1;
        req_amount = 8'd100;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !eject_valid; i++) @(negedge clk);
        check("mid_ev_before", 32'(eject_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ev", 32'(eject_valid), 32'd0);
        check("mid_sel", 32'(eject_sel), 32'd0);
        check("mid_ready", 32'(req_ready), 32'd1);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("mid_no_done", 32'(saw_done), 32'd0);
        check("mid_ready_after", 32'(req_ready), 32'd1);
        check("mid_ev_after", 32'(eject_valid), 32'd0);

        run_txn("t10post", 8'd10, 5'b00000, 5'b00000, 1, 1'b0, 1'b0,
                {15'b0, 5'b00001}, 1, 8'd0, 5'd1, 5'd0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
